// File: rtl/i2c_serdes.sv
// I2C byte serializer/deserializer between the master state machine and the pads.
// Transmits 1..NUM_BYTES latched bytes MSB first; captures received bytes into a parallel buffer.
module i2c_serdes #(
  parameter int NUM_BYTES = 8,
  localparam int CW = $clog2(NUM_BYTES + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLK_EN,
  input  logic [8*NUM_BYTES-1:0] DATA_FROM_CORE,
  input  logic [CW-1:0]          TX_BYTES,
  input  logic                   LATCH_CORE_SIDE_REG,
  input  logic                   LOAD_SHIFTREG,
  input  logic                   SHIFT_OUT,
  input  logic                   SHIFT_IN,
  input  logic                   SAMPLE_ACK,
  input  logic                   CLR_STATUS,
  input  logic                   SDA_SEL_SM,
  input  logic                   SCL_SM,
  input  logic                   SDA_DIR_SM,
  input  logic                   SDA_OUT_SM,
  input  logic                   SDA_IN,
  output logic                   SCL,
  output logic                   SDA_DIR,
  output logic                   SDA_OUT,
  output logic [8*NUM_BYTES-1:0] DATA_TO_CORE,
  output logic [CW-1:0]          RX_BYTES,
  output logic                   TX_EMPTY,
  output logic                   BYTE_DONE,
  output logic                   NACK
);

  localparam logic [CW-1:0] MAX_BYTES = CW'(NUM_BYTES);

  logic                   sda_meta;
  logic                   sda_sync;
  logic [8*NUM_BYTES-1:0] tx_buf;
  logic [CW-1:0]          tx_remaining;
  logic [7:0]             data_out;
  logic [3:0]             tx_bit_cnt;
  logic [7:0]             rx_sr;
  logic [2:0]             rx_bit_cnt;
  logic                   tx_done;
  logic                   rx_done;

  assign TX_EMPTY = (tx_remaining == '0);

  always_comb begin
    tx_done = CLK_EN && !LATCH_CORE_SIDE_REG && !LOAD_SHIFTREG && SHIFT_OUT
              && (tx_bit_cnt == 4'd7);
    rx_done = CLK_EN && !CLR_STATUS && SHIFT_IN && (rx_bit_cnt == 3'd7);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= SDA_IN;
      sda_sync <= sda_meta;
    end
  end

  // Transmit path: latch beats load beats shift. tx_bit_cnt parks at 8 so
  // extra shifts after a full byte never re-signal completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_buf       <= '0;
      tx_remaining <= '0;
      data_out     <= '0;
      tx_bit_cnt   <= '0;
    end else if (CLK_EN) begin
      if (LATCH_CORE_SIDE_REG) begin
        tx_buf       <= DATA_FROM_CORE;
        tx_remaining <= (TX_BYTES > MAX_BYTES) ? MAX_BYTES : TX_BYTES;
      end else if (LOAD_SHIFTREG) begin
        tx_bit_cnt <= '0;
        if (tx_remaining != '0) begin
          data_out     <= tx_buf[7:0];
          tx_buf       <= tx_buf >> 8;
          tx_remaining <= tx_remaining - 1'b1;
        end else begin
          data_out <= 8'h00;
        end
      end else if (SHIFT_OUT) begin
        data_out <= {data_out[6:0], 1'b0};
        if (tx_bit_cnt != 4'd8) tx_bit_cnt <= tx_bit_cnt + 4'd1;
      end
    end
  end

  // Receive path and status; completed bytes beyond the buffer depth are dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_sr        <= '0;
      rx_bit_cnt   <= '0;
      RX_BYTES     <= '0;
      DATA_TO_CORE <= '0;
      NACK         <= 1'b0;
    end else if (CLK_EN) begin
      if (CLR_STATUS) begin
        NACK       <= 1'b0;
        RX_BYTES   <= '0;
        rx_bit_cnt <= '0;
      end else begin
        if (SAMPLE_ACK && sda_sync) NACK <= 1'b1;
        if (SHIFT_IN) begin
          rx_sr <= {rx_sr[6:0], sda_sync};
          if (rx_bit_cnt == 3'd7) begin
            rx_bit_cnt <= '0;
            if (RX_BYTES != MAX_BYTES) begin
              for (int k = 0; k < NUM_BYTES; k++) begin
                if (RX_BYTES == CW'(k)) DATA_TO_CORE[8*k +: 8] <= {rx_sr[6:0], sda_sync};
              end
              RX_BYTES <= RX_BYTES + 1'b1;
            end
          end else begin
            rx_bit_cnt <= rx_bit_cnt + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) BYTE_DONE <= 1'b0;
    else     BYTE_DONE <= tx_done | rx_done;
  end

  // Pad outputs are registered every CLK, independent of the bit-rate enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SCL     <= 1'b1;
      SDA_DIR <= 1'b0;
      SDA_OUT <= 1'b1;
    end else begin
      SCL     <= SCL_SM;
      SDA_DIR <= SDA_DIR_SM;
      SDA_OUT <= SDA_SEL_SM ? SDA_OUT_SM : data_out[7];
    end
  end

endmodule

// File: tb/tb_i2c_serdes.sv
// Directed bench for i2c_serdes: an 8-byte instance plus a 2-byte instance
// sharing control inputs to exercise clamping and receive overflow.
module tb_i2c_serdes;

  logic        CLK, RST, CLK_EN;
  logic [63:0] data_from_core;
  logic [15:0] data_from_core_s;
  logic [3:0]  tx_bytes;
  logic [1:0]  tx_bytes_s;
  logic        latch, load, shift_out, shift_in, sample_ack, clr_status;
  logic        sda_sel_sm, scl_sm, sda_dir_sm, sda_out_sm, sda_in;

  logic        scl, sda_dir, sda_out, tx_empty, byte_done, nack;
  logic [63:0] data_to_core;
  logic [3:0]  rx_bytes;
  logic        scl_s, sda_dir_s, sda_out_s, tx_empty_s, byte_done_s, nack_s;
  logic [15:0] data_to_core_s;
  logic [1:0]  rx_bytes_s;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  i2c_serdes #(.NUM_BYTES(8)) u_dut (
    .CLK(CLK), .RST(RST), .CLK_EN(CLK_EN),
    .DATA_FROM_CORE(data_from_core), .TX_BYTES(tx_bytes),
    .LATCH_CORE_SIDE_REG(latch), .LOAD_SHIFTREG(load), .SHIFT_OUT(shift_out),
    .SHIFT_IN(shift_in), .SAMPLE_ACK(sample_ack), .CLR_STATUS(clr_status),
    .SDA_SEL_SM(sda_sel_sm), .SCL_SM(scl_sm), .SDA_DIR_SM(sda_dir_sm),
    .SDA_OUT_SM(sda_out_sm), .SDA_IN(sda_in),
    .SCL(scl), .SDA_DIR(sda_dir), .SDA_OUT(sda_out), .DATA_TO_CORE(data_to_core),
    .RX_BYTES(rx_bytes), .TX_EMPTY(tx_empty), .BYTE_DONE(byte_done), .NACK(nack)
  );

  i2c_serdes #(.NUM_BYTES(2)) u_small (
    .CLK(CLK), .RST(RST), .CLK_EN(CLK_EN),
    .DATA_FROM_CORE(data_from_core_s), .TX_BYTES(tx_bytes_s),
    .LATCH_CORE_SIDE_REG(latch), .LOAD_SHIFTREG(load), .SHIFT_OUT(shift_out),
    .SHIFT_IN(shift_in), .SAMPLE_ACK(sample_ack), .CLR_STATUS(clr_status),
    .SDA_SEL_SM(sda_sel_sm), .SCL_SM(scl_sm), .SDA_DIR_SM(sda_dir_sm),
    .SDA_OUT_SM(sda_out_sm), .SDA_IN(sda_in),
    .SCL(scl_s), .SDA_DIR(sda_dir_s), .SDA_OUT(sda_out_s), .DATA_TO_CORE(data_to_core_s),
    .RX_BYTES(rx_bytes_s), .TX_EMPTY(tx_empty_s), .BYTE_DONE(byte_done_s), .NACK(nack_s)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One CLK edge; outputs are sampled 1 ns after it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_empty);
    load = 1'b1;
    cyc();
    load = 1'b0;
    check({tag, "_tx_empty"}, 64'(tx_empty), 64'(exp_empty));
    shift_out = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      cyc();
      check({tag, "_sda"}, 64'(sda_out), 64'(b[i]));
      check({tag, "_done"}, 64'(byte_done), 64'(i == 0));
      if (byte_done) done_cnt++;
    end
    shift_out = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_in = b[i];
      cyc();
      cyc();
      shift_in = 1'b1;
      cyc();
      shift_in = 1'b0;
      check({tag, "_done"}, 64'(byte_done), 64'(i == 0));
      check({tag, "_done_s"}, 64'(byte_done_s), 64'(i == 0));
    end
  endtask

  initial begin
    RST = 1'b1; CLK_EN = 1'b1;
    data_from_core = '0; data_from_core_s = '0; tx_bytes = '0; tx_bytes_s = '0;
    latch = 0; load = 0; shift_out = 0; shift_in = 0; sample_ack = 0; clr_status = 0;
    sda_sel_sm = 0; scl_sm = 1; sda_dir_sm = 0; sda_out_sm = 1; sda_in = 1;
    cyc(); cyc();
    check("rst_scl", 64'(scl), 64'd1);
    check("rst_sda_dir", 64'(sda_dir), 64'd0);
    check("rst_sda_out", 64'(sda_out), 64'd1);
    check("rst_tx_empty", 64'(tx_empty), 64'd1);
    check("rst_rx_bytes", 64'(rx_bytes), 64'd0);
    check("rst_nack", 64'(nack), 64'd0);
    check("rst_byte_done", 64'(byte_done), 64'd0);
    check("rst_data", data_to_core, 64'd0);
    RST = 1'b0;
    cyc();

    // Three-byte transmit; small instance clamps TX_BYTES=3 to 2.
    data_from_core = 64'h0000_0000_0002_01A5;
    tx_bytes = 4'd3;
    data_from_core_s = 16'h1234;
    tx_bytes_s = 2'd3;
    latch = 1'b1;
    cyc();
    latch = 1'b0;
    check("latch_tx_empty", 64'(tx_empty), 64'd0);
    send_byte("b0", 8'hA5, 1'b0);
    check("s_after1_empty", 64'(tx_empty_s), 64'd0);
    send_byte("b1", 8'h01, 1'b0);
    check("s_after2_empty", 64'(tx_empty_s), 64'd1);
    send_byte("b2", 8'h02, 1'b1);
    check("tx_done_count", 64'(done_cnt), 64'd3);
    cyc();
    check("done_stays_low", 64'(byte_done), 64'd0);

    // Empty-buffer load pushes 0x00; precondition SDA_OUT=1 via SM select.
    sda_sel_sm = 1'b1; sda_out_sm = 1'b1;
    cyc();
    check("sel_sm_high", 64'(sda_out), 64'd1);
    sda_sel_sm = 1'b0;
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    check("empty_load_sda", 64'(sda_out), 64'd0);
    check("empty_load_tx_empty", 64'(tx_empty), 64'd1);

    // Receive 0x3C, 0xC3, 0x5A; the 2-byte instance drops the third.
    recv_byte("r0", 8'h3C);
    recv_byte("r1", 8'hC3);
    check("rx_data16", 64'(data_to_core[15:0]), 64'h0000_0000_0000_C33C);
    check("rx_bytes2", 64'(rx_bytes), 64'd2);
    check("s_rx_bytes2", 64'(rx_bytes_s), 64'd2);
    recv_byte("r2", 8'h5A);
    check("rx_data24", 64'(data_to_core[23:0]), 64'h0000_0000_005A_C33C);
    check("rx_bytes3", 64'(rx_bytes), 64'd3);
    check("s_rx_sat", 64'(rx_bytes_s), 64'd2);
    check("s_rx_drop", 64'(data_to_core_s), 64'h0000_0000_0000_C33C);

    // NACK: ignored when CLK_EN=0, sticky, cleared by CLR_STATUS.
    sda_in = 1'b1;
    cyc(); cyc();
    CLK_EN = 1'b0; sample_ack = 1'b1;
    cyc();
    check("nack_gated", 64'(nack), 64'd0);
    CLK_EN = 1'b1;
    cyc();
    sample_ack = 1'b0;
    check("nack_set", 64'(nack), 64'd1);
    sda_in = 1'b0;
    cyc(); cyc();
    sample_ack = 1'b1;
    cyc();
    sample_ack = 1'b0;
    check("nack_sticky", 64'(nack), 64'd1);
    clr_status = 1'b1; sample_ack = 1'b1; sda_in = 1'b1;
    cyc(); cyc(); cyc();
    clr_status = 1'b0; sample_ack = 1'b0;
    check("clr_nack", 64'(nack), 64'd0);
    check("clr_rx_bytes", 64'(rx_bytes), 64'd0);
    check("clr_keeps_data", 64'(data_to_core[23:0]), 64'h0000_0000_005A_C33C);

    // SM-side control lines.
    sda_sel_sm = 1'b1; sda_out_sm = 1'b1;
    cyc();
    check("sm_sda_hi", 64'(sda_out), 64'd1);
    sda_out_sm = 1'b0; scl_sm = 1'b0; sda_dir_sm = 1'b1;
    cyc();
    check("sm_sda_lo", 64'(sda_out), 64'd0);
    check("sm_scl_lo", 64'(scl), 64'd0);
    check("sm_dir_hi", 64'(sda_dir), 64'd1);

    // Reset in the middle of a byte.
    sda_sel_sm = 1'b0;
    tx_bytes = 4'd2;
    latch = 1'b1;
    cyc();
    latch = 1'b0;
    load = 1'b1;
    cyc();
    load = 1'b0; shift_out = 1'b1;
    cyc(); cyc();
    shift_out = 1'b0;
    check("pre_rst_sda", 64'(sda_out), 64'd0);
    check("pre_rst_empty", 64'(tx_empty), 64'd0);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_scl", 64'(scl), 64'd1);
    check("mid_rst_dir", 64'(sda_dir), 64'd0);
    check("mid_rst_sda", 64'(sda_out), 64'd1);
    check("mid_rst_empty", 64'(tx_empty), 64'd1);
    check("mid_rst_data", data_to_core, 64'd0);
    cyc();
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
